// File: rtl/countdown_control.sv
`timescale 1ns/1ps
// Control stage for the seconds/tens/minutes downcounter chain. It debounces the
// start and clear buttons, runs the timer state machine, paces counting and blinks the alarm.
module countdown_control #(
    parameter int TICK_DIV    = 100,
    parameter int DEBOUNCE    = 8,
    parameter int ALARM_TICKS = 10,
    parameter int MIN_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_start,
    input  logic             btn_clear,
    input  logic [MIN_W-1:0] sw_minutes,
    input  logic             all_zero,
    output logic             load,
    output logic [MIN_W-1:0] load_minutes,
    output logic             count_en,
    output logic             running,
    output logic             alarm,
    output logic [1:0]       state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
    localparam int B_START = 0;
    localparam int B_CLEAR = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    logic [1:0]         raw_p0;
    logic [1:0]         raw_p1;
    logic [1:0]         deb_lvl;
    logic [1:0][DW-1:0] deb_cnt;
    logic [1:0]         press;

    state_t           state_q, state_n;
    logic [PW-1:0]    presc_q, presc_n, presc_inc;
    logic [AW-1:0]    acnt_q, acnt_n;
    logic [MIN_W-1:0] lmin_n;
    logic             load_n, cen_n, alarm_n;
    logic             start_hit, clear_hit, presc_wrap;

    // Button path: two-stage synchronizer, then a level that only follows a
    // sustained mismatch; the press pulse fires on the accepted rising level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raw_p0  <= '0;
            raw_p1  <= '0;
            deb_lvl <= '0;
            deb_cnt <= '0;
            press   <= '0;
        end else begin
            raw_p0 <= {btn_clear, btn_start};
            raw_p1 <= raw_p0;
            press  <= '0;
            for (int i = 0; i < 2; i++) begin
                if (raw_p1[i] != deb_lvl[i]) begin
                    if (deb_cnt[i] == DW'(DEBOUNCE - 1)) begin
                        deb_lvl[i] <= raw_p1[i];
                        deb_cnt[i] <= '0;
                        press[i]   <= raw_p1[i];
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign clear_hit  = press[B_CLEAR];
    assign start_hit  = press[B_START] & ~press[B_CLEAR];
    assign presc_inc  = presc_q + 1'b1;
    assign presc_wrap = (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        state_n = state_q;
        presc_n = presc_q;
        acnt_n  = acnt_q;
        lmin_n  = load_minutes;
        load_n  = 1'b0;
        cen_n   = 1'b0;
        alarm_n = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_hit) begin
                    load_n  = 1'b1;
                    lmin_n  = sw_minutes;
                    state_n = RUNNING;
                    presc_n = '0;
                end
            end
            RUNNING: begin
                if (clear_hit) begin
                    load_n  = 1'b1;
                    state_n = IDLE;
                    presc_n = '0;
                end else if (start_hit) begin
                    state_n = PAUSED;
                end else if (presc_wrap) begin
                    presc_n = '0;
                    if (all_zero) begin
                        state_n = EXPIRED;
                        acnt_n  = '0;
                        alarm_n = 1'b1;
                    end else begin
                        cen_n = 1'b1;
                    end
                end else begin
                    presc_n = presc_inc;
                end
            end
            PAUSED: begin
                if (clear_hit) begin
                    load_n  = 1'b1;
                    state_n = IDLE;
                    presc_n = '0;
                end else if (start_hit) begin
                    state_n = RUNNING;
                end
            end
            EXPIRED: begin
                // Either button silences the alarm; otherwise blink for a fixed number of periods.
                if (clear_hit || start_hit) begin
                    state_n = IDLE;
                    presc_n = '0;
                end else if (presc_wrap) begin
                    presc_n = '0;
                    if (acnt_q == AW'(ALARM_TICKS - 1)) begin
                        state_n = IDLE;
                    end else begin
                        acnt_n  = acnt_q + 1'b1;
                        alarm_n = 1'b1;
                    end
                end else begin
                    presc_n = presc_inc;
                    alarm_n = (presc_inc < PW'(TICK_DIV / 2));
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            acnt_q       <= '0;
            load         <= 1'b0;
            load_minutes <= '0;
            count_en     <= 1'b0;
            running      <= 1'b0;
            alarm        <= 1'b0;
        end else begin
            state_q      <= state_n;
            presc_q      <= presc_n;
            acnt_q       <= acnt_n;
            load         <= load_n;
            load_minutes <= lmin_n;
            count_en     <= cen_n;
            running      <= (state_n == RUNNING);
            alarm        <= alarm_n;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_countdown_control.sv
`timescale 1ns/1ps
// Bench for countdown_control: a timeline model predicts output events from the
// button presses and all_zero it drives; a separate monitor compares DUT events in order.
module tb_countdown_control;
    localparam int TD  = 10;
    localparam int DEB = 4;
    localparam int AT  = 3;
    localparam int MW  = 4;
    localparam int K_LOAD = 0, K_CEN = 1, K_STATE = 2, K_ALARM = 3;
    // State event values are {running, state}
    localparam int V_IDLE = 0, V_RUN = 5, V_PAUSE = 2, V_EXP = 3;

    typedef struct { int kind; int t; int val; } ev_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          btn_start = 1'b0;
    logic          btn_clear = 1'b0;
    logic          all_zero = 1'b0;
    logic [MW-1:0] sw_minutes = '0;
    logic          load, count_en, running, alarm;
    logic [MW-1:0] load_minutes;
    logic [1:0]    state;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  load_cnt = 0, cen_cnt = 0, alarm_hi = 0;
    bit  mon_on = 1'b0;
    ev_t exp_q[$];

    // Model: mode, next count boundary, remaining cycles on resume, expiry start and step
    int ms = 0, nb = 0, rem = 0, xc = 0, xk = 0, lm = 0, last_load = 0;
    bit mal = 1'b0, mz = 1'b0;

    countdown_control #(.TICK_DIV(TD), .DEBOUNCE(DEB), .ALARM_TICKS(AT), .MIN_W(MW)) dut (
        .clk(clk), .reset(reset), .btn_start(btn_start), .btn_clear(btn_clear),
        .sw_minutes(sw_minutes), .all_zero(all_zero), .load(load),
        .load_minutes(load_minutes), .count_en(count_en), .running(running),
        .alarm(alarm), .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    function automatic string kname(input int k);
        case (k)
            K_LOAD:  return "load";
            K_CEN:   return "count_en";
            K_STATE: return "state";
            default: return "alarm";
        endcase
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic void push(input int k, input int t, input int v);
        ev_t e;
        e.kind = k; e.t = t; e.val = v;
        exp_q.push_back(e);
    endfunction

    // Emit every predicted event strictly before cycle t.
    function automatic void advance(input int t);
        bit go;
        int et;
        go = 1'b1;
        while (go) begin
            go = 1'b0;
            if (ms == 1 && nb < t) begin
                if (mz) begin
                    push(K_STATE, nb, V_EXP); push(K_ALARM, nb, 1);
                    ms = 3; mal = 1'b1; xc = nb; xk = 1;
                end else begin
                    push(K_CEN, nb, 0);
                    nb += TD;
                end
                go = 1'b1;
            end else if (ms == 3 && xc + xk * (TD / 2) < t) begin
                et = xc + xk * (TD / 2);
                if (xk == 2 * AT) begin
                    push(K_STATE, et, V_IDLE);
                    ms = 0;
                end else begin
                    mal = (xk % 2 == 0);
                    push(K_ALARM, et, int'(mal));
                    xk++;
                end
                go = 1'b1;
            end
        end
    endfunction

    // A debounced press (or coincident pair) takes effect on the outputs at cycle t.
    function automatic void action(input bit s, input bit c, input int t);
        bit st;
        advance(t);
        st = s & ~c;
        case (ms)
            0: if (st) begin
                push(K_LOAD, t, int'(sw_minutes)); push(K_STATE, t, V_RUN);
                lm = int'(sw_minutes); ms = 1; nb = t + TD; last_load = t;
            end
            1: if (c) begin
                push(K_LOAD, t, lm); push(K_STATE, t, V_IDLE); ms = 0;
            end else if (st) begin
                rem = nb - t + 1; push(K_STATE, t, V_PAUSE); ms = 2;
            end
            2: if (c) begin
                push(K_LOAD, t, lm); push(K_STATE, t, V_IDLE); ms = 0;
            end else if (st) begin
                push(K_STATE, t, V_RUN); ms = 1; nb = t + rem;
            end
            default: if (c || st) begin
                push(K_STATE, t, V_IDLE);
                if (mal) push(K_ALARM, t, 0);
                mal = 1'b0; ms = 0;
            end
        endcase
    endfunction

    task automatic wait_cyc(input int k);
        for (int i = 0; i < k; i++) begin
            advance(cyc + 2);
            @(negedge clk);
        end
    endtask

    task automatic set_zero(input bit v);
        mz = v;
        all_zero = v;
    endtask

    // Bounce (2-cycle levels) then a clean hold; raw edge at cycle n gives action at n+3+DEB.
    task automatic press(input bit s, input bit c, input int bounces);
        for (int i = 0; i < bounces; i++) begin
            btn_start = s & (i % 2 == 0);
            btn_clear = c & (i % 2 == 0);
            wait_cyc(2);
        end
        btn_start = s;
        btn_clear = c;
        action(s, c, cyc + 3 + DEB);
        wait_cyc(DEB + 6);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        wait_cyc(DEB + 4);
    endtask

    task automatic observe(input int k, input int v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got event at t=%0d val=%0d, expected no event", kname(k), cyc, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.t != cyc || e.val != v) begin
                errors++;
                $display("FAIL %s_event: got %s t=%0d val=%0d, expected %s t=%0d val=%0d",
                         kname(e.kind), kname(k), cyc, v, kname(e.kind), e.t, e.val);
            end
        end
    endtask

    initial begin
        logic [2:0] prev_st;
        logic       prev_al;
        prev_st = '0;
        prev_al = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                if (load) begin
                    observe(K_LOAD, int'(load_minutes));
                    load_cnt++;
                end
                if (count_en) begin
                    observe(K_CEN, 0);
                    cen_cnt++;
                end
                if ({running, state} != prev_st) observe(K_STATE, int'({running, state}));
                if (alarm != prev_al) observe(K_ALARM, int'(alarm));
                if (alarm) alarm_hi++;
            end
            prev_st = {running, state};
            prev_al = alarm;
        end
    end

    initial begin
        int c, lc0, cc0, ac0, op;
        @(negedge clk);
        @(negedge clk);
        chk("init_state", int'(state), 0);
        chk("init_load", int'(load), 0);
        chk("init_count_en", int'(count_en), 0);
        chk("init_running", int'(running), 0);
        chk("init_alarm", int'(alarm), 0);
        chk("init_load_minutes", int'(load_minutes), 0);
        reset = 1'b0;
        mon_on = 1'b1;
        wait_cyc(3);

        // Bounced start press: one load carrying 3, then clear back to IDLE
        sw_minutes = 4'd3;
        lc0 = load_cnt;
        press(1'b1, 1'b0, 10);
        chk("bounce_load_count", load_cnt - lc0, 1);
        chk("bounce_load_minutes", int'(load_minutes), 3);
        press(1'b0, 1'b1, 0);

        // Three counts, then all_zero before the fourth boundary expires the timer
        sw_minutes = 4'd1;
        set_zero(1'b0);
        cc0 = cen_cnt;
        press(1'b1, 1'b0, 0);
        wait_cyc(last_load + 31 - cyc);
        set_zero(1'b1);
        wait_cyc(last_load + 75 - cyc);
        chk("run_cen_count", cen_cnt - cc0, 3);
        chk("run_end_state", int'(state), 0);

        // Pause four cycles after a count pulse, hold 50 cycles, resume, then clear+start together
        set_zero(1'b0);
        sw_minutes = 4'd2;
        press(1'b1, 1'b0, 0);
        c = nb;
        while (c + 2 - DEB < cyc) c += TD;
        wait_cyc(c + 2 - DEB - cyc);
        press(1'b1, 1'b0, 0);
        cc0 = cen_cnt;
        wait_cyc(50);
        chk("paused_no_cen", cen_cnt - cc0, 0);
        chk("paused_state", int'(state), 2);
        press(1'b1, 1'b0, 0);
        wait_cyc(20);
        lc0 = load_cnt;
        press(1'b1, 1'b1, 0);
        chk("clear_wins_state", int'(state), 0);
        chk("clear_wins_loads", load_cnt - lc0, 1);

        // Zero start value: immediate expiry, three blink periods, silent return
        sw_minutes = 4'd0;
        set_zero(1'b1);
        cc0 = cen_cnt; lc0 = load_cnt; ac0 = alarm_hi;
        press(1'b1, 1'b0, 0);
        wait_cyc(last_load + 45 - cyc);
        chk("zero_min_cen", cen_cnt - cc0, 0);
        chk("zero_min_loads", load_cnt - lc0, 1);
        chk("alarm_high_cycles", alarm_hi - ac0, 3 * (TD / 2));
        chk("alarm_end_state", int'(state), 0);

        // Expiry cut short by a clear press
        press(1'b1, 1'b0, 0);
        wait_cyc(3);
        press(1'b0, 1'b1, 0);
        chk("expiry_abort_alarm", int'(alarm), 0);
        set_zero(1'b0);

        // Asynchronous reset while running
        sw_minutes = 4'd5;
        press(1'b1, 1'b0, 0);
        wait_cyc(13);
        mon_on = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_async_state", int'(state), 0);
        chk("rst_async_load", int'(load), 0);
        chk("rst_async_count_en", int'(count_en), 0);
        chk("rst_async_running", int'(running), 0);
        chk("rst_async_alarm", int'(alarm), 0);
        chk("rst_async_load_minutes", int'(load_minutes), 0);
        exp_q.delete();
        ms = 0; lm = 0; mal = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mon_on = 1'b1;
        lc0 = load_cnt;
        wait_cyc(30);
        chk("no_load_after_reset", load_cnt - lc0, 0);

        // Randomized operation sequence
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                sw_minutes = MW'($urandom_range(0, 15));
                press(1'b1, 1'b0, 2 * $urandom_range(0, 3));
            end else if (op <= 5) begin
                press(1'b0, 1'b1, 2 * $urandom_range(0, 2));
            end else if (op == 6) begin
                press(1'b1, 1'b1, 0);
            end else if (op == 7) begin
                set_zero(1'($urandom_range(0, 1)));
            end else begin
                wait_cyc($urandom_range(1, 30));
            end
        end

        press(1'b0, 1'b1, 0);
        wait_cyc(5);
        chk("final_state", int'(state), 0);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
